// File: rtl/mod_count_pkg.sv
// Shared definitions for mod-N counter monitoring: state encoding, default
// geometry, and the successor function used by counters, checkers and models.
// Combinational helpers only; no latency, no flow control.
package mod_count_pkg;

  // Checker lock state; 2-bit encoding, value 3 is unreachable.
  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int unsigned DEF_N     = 10;
  localparam int unsigned DEF_WIDTH = 4;

  // Next value of a mod-n sequence. Wraps at n-1 explicitly so the result
  // never exceeds n-1, even when n is exactly 2**WIDTH of the caller.
  function automatic logic [31:0] succ(input logic [31:0] v, input logic [31:0] n);
    return (v == n - 32'd1) ? 32'd0 : v + 32'd1;
  endfunction

endpackage

// File: rtl/mod_count_checker.sv
// Receive-side monitor for a mod-N counter stream: locks after SYNC_LEN correct
// successors, then flags every deviation. All outputs registered, 1 cycle after
// the sampling edge. No backpressure: cycles with count_vld=0 are simply ignored.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   count_in      observed counter value, qualified by count_vld
//   err_clr       clears err_count (and err_sticky when compiled in)
//   locked        high while in LOCKED state
//   expected      next value expected (meaningful when locked)
//   err_pulse     one-cycle pulse per detected error
//   err_count     saturating error count
//   wrap_count    number of locked N-1 -> 0 transitions (wrapping)
//   err_sticky    sticky error flag; only live with MOD_COUNT_CHECKER_STICKY_EN,
//                 otherwise tied to 0
module mod_count_checker
  import mod_count_pkg::*;
#(
  parameter int unsigned N        = DEF_N,
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned SYNC_LEN = 2,
  parameter int unsigned ERR_W    = 8,
  parameter int unsigned WRAP_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              count_vld,
  input  logic              err_clr,
  output logic              locked,
  output logic [WIDTH-1:0]  expected,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              err_sticky
);

  localparam int unsigned    RUN_W    = $clog2(SYNC_LEN + 1);
  localparam logic [31:0]    N_U      = 32'(N);
  localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(SYNC_LEN);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   exp_q, exp_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               pulse_q, pulse_d;
  logic [ERR_W-1:0]   errc_q, errc_d;
  logic [WRAP_W-1:0]  wrap_q, wrap_d;

  logic               in_range;
  logic               match;
  logic               is_last;
  logic [WIDTH-1:0]   succ_in;
  logic [RUN_W-1:0]   run_inc;

  assign in_range = (32'(count_in) < N_U);
  assign match    = (count_in == exp_q);
  assign is_last  = (32'(count_in) == N_U - 32'd1);
  assign succ_in  = WIDTH'(succ(32'(count_in), N_U));
  assign run_inc  = run_q + RUN_W'(1);

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    run_d   = run_q;
    pulse_d = 1'b0;
    errc_d  = errc_q;
    wrap_d  = wrap_q;

    if (count_vld) begin
      unique case (state_q)
        UNSYNC: begin
          // Out-of-range values cannot seed a sequence; wait for a usable one.
          if (in_range) begin
            exp_d   = succ_in;
            run_d   = '0;
            state_d = SYNC;
          end
        end
        SYNC: begin
          if (match) begin
            exp_d = succ_in;
            run_d = run_inc;
            if (run_inc == RUN_LOCK) state_d = LOCKED;
          end else if (in_range) begin
            // Re-seed from the new value rather than dropping to UNSYNC.
            exp_d = succ_in;
            run_d = '0;
          end else begin
            run_d   = '0;
            state_d = UNSYNC;
          end
        end
        LOCKED: begin
          // expected is always < N here, so out-of-range input lands in the
          // mismatch branch without a separate check.
          if (match) begin
            exp_d = succ_in;
            if (is_last) wrap_d = wrap_q + WRAP_W'(1);
          end else begin
            pulse_d = 1'b1;
            state_d = UNSYNC;
            if (errc_q != '1) errc_d = errc_q + ERR_W'(1);
          end
        end
        default: state_d = UNSYNC;
      endcase
    end

    // Clear has priority over a same-cycle increment.
    if (err_clr) errc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNSYNC;
      exp_q   <= '0;
      run_q   <= '0;
      pulse_q <= 1'b0;
      errc_q  <= '0;
      wrap_q  <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      run_q   <= run_d;
      pulse_q <= pulse_d;
      errc_q  <= errc_d;
      wrap_q  <= wrap_d;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign expected   = exp_q;
  assign err_pulse  = pulse_q;
  assign err_count  = errc_q;
  assign wrap_count = wrap_q;

`ifdef MOD_COUNT_CHECKER_STICKY_EN
  logic sticky_q;

  // Clear beats a same-cycle set.
  always_ff @(posedge clk) begin
    if (rst)          sticky_q <= 1'b0;
    else if (err_clr) sticky_q <= 1'b0;
    else if (pulse_d) sticky_q <= 1'b1;
  end

  assign err_sticky = sticky_q;
`else
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_mod_count_checker.sv
// Directed self-checking bench for mod_count_checker (N=10, WIDTH=4, SYNC_LEN=2,
// ERR_W=8, WRAP_W=16). Inputs change 1 time unit after each rising edge and
// outputs are sampled at the same point, i.e. one edge after the sample.
module tb_mod_count_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  count_in;
  logic        count_vld;
  logic        err_clr;
  logic        locked;
  logic [3:0]  expected;
  logic        err_pulse;
  logic [7:0]  err_count;
  logic [15:0] wrap_count;
  logic        err_sticky;

  int checks = 0;
  int errors = 0;

`ifdef MOD_COUNT_CHECKER_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  mod_count_checker #(
    .N(10), .WIDTH(4), .SYNC_LEN(2), .ERR_W(8), .WRAP_W(16)
  ) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .count_vld(count_vld),
    .err_clr(err_clr), .locked(locked), .expected(expected),
    .err_pulse(err_pulse), .err_count(err_count), .wrap_count(wrap_count),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then land 1 unit after the capturing edge.
  task automatic step(input logic r, input logic v, input logic [3:0] c, input logic clr);
    rst       = r;
    count_vld = v;
    count_in  = c;
    err_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; count_vld = 1'b0; count_in = 4'd0; err_clr = 1'b0;

    // 1: reset, then idle
    repeat (3) step(1'b1, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b0);
    chk("rst_locked", locked, 0);
    chk("rst_expected", expected, 0);
    chk("rst_pulse", err_pulse, 0);
    chk("rst_errc", err_count, 0);
    chk("rst_wrap", wrap_count, 0);
    chk("rst_sticky", err_sticky, 0);

    // 2: clean stream 0..9 twice
    step(1'b0, 1'b1, 4'd0, 1'b0);
    chk("lk0_locked", locked, 0);
    chk("lk0_expected", expected, 1);
    step(1'b0, 1'b1, 4'd1, 1'b0);
    chk("lk1_locked", locked, 0);
    step(1'b0, 1'b1, 4'd2, 1'b0);
    chk("lk2_locked", locked, 1);
    chk("lk2_expected", expected, 3);
    for (int i = 3; i < 10; i++) begin
      step(1'b0, 1'b1, 4'(i), 1'b0);
      chk("run_expected", expected, (i + 1) % 10);
      chk("run_locked", locked, 1);
    end
    chk("wrap_first", wrap_count, 1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 4'(i), 1'b0);
    chk("wrap_second", wrap_count, 2);
    chk("clean_errc", err_count, 0);
    chk("clean_pulse", err_pulse, 0);

    // 3: inject 5 where 4 expected, then relock on 6,7,8
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'(i), 1'b0);
    chk("pre_inj_expected", expected, 4);
    step(1'b0, 1'b1, 4'd5, 1'b0);
    chk("inj_pulse", err_pulse, 1);
    chk("inj_errc", err_count, 1);
    chk("inj_locked", locked, 0);
    step(1'b0, 1'b1, 4'd6, 1'b0);
    chk("inj_pulse_end", err_pulse, 0);
    chk("relock6_locked", locked, 0);
    step(1'b0, 1'b1, 4'd7, 1'b0);
    chk("relock7_locked", locked, 0);
    step(1'b0, 1'b1, 4'd8, 1'b0);
    chk("relock8_locked", locked, 1);
    chk("relock8_expected", expected, 9);
    chk("relock_errc", err_count, 1);

    // 4: clear, then out-of-range value while locked
    step(1'b0, 1'b0, 4'd0, 1'b1);
    chk("clr_errc", err_count, 0);
    chk("clr_keeps_locked", locked, 1);
    chk("clr_keeps_expected", expected, 9);
    chk("clr_keeps_wrap", wrap_count, 2);
    step(1'b0, 1'b1, 4'd12, 1'b0);
    chk("oor_pulse", err_pulse, 1);
    chk("oor_errc", err_count, 1);
    chk("oor_locked", locked, 0);
    step(1'b0, 1'b1, 4'd12, 1'b0);
    chk("unsync12_pulse", err_pulse, 0);
    step(1'b0, 1'b1, 4'd13, 1'b0);
    chk("unsync13_pulse", err_pulse, 0);
    chk("unsync_errc", err_count, 1);
    chk("unsync_locked", locked, 0);
    step(1'b0, 1'b1, 4'd3, 1'b0);
    chk("seed_expected", expected, 4);
    chk("seed_locked", locked, 0);
    // SYNC mismatch re-seeds silently
    step(1'b0, 1'b1, 4'd7, 1'b0);
    chk("reseed_expected", expected, 8);
    chk("reseed_pulse", err_pulse, 0);
    step(1'b0, 1'b1, 4'd8, 1'b0);
    chk("reseed8_locked", locked, 0);
    step(1'b0, 1'b1, 4'd9, 1'b0);
    chk("reseed9_locked", locked, 1);
    chk("reseed9_expected", expected, 0);
    chk("sync_no_wrap", wrap_count, 2);
    chk("reseed_errc", err_count, 1);

    // 5: 300 further errors saturate the 8-bit counter
    for (int k = 0; k < 300; k++) begin
      step(1'b0, 1'b1, 4'd0, 1'b0);
      step(1'b0, 1'b1, 4'd1, 1'b0);
      step(1'b0, 1'b1, 4'd2, 1'b0);
      step(1'b0, 1'b1, 4'd5, 1'b0);
    end
    chk("sat_errc", err_count, 255);
    chk("sat_pulse", err_pulse, 1);
    chk("sat_sticky", err_sticky, STICKY);
    // error together with clear: clear wins, pulse still fires
    step(1'b0, 1'b1, 4'd0, 1'b0);
    step(1'b0, 1'b1, 4'd1, 1'b0);
    step(1'b0, 1'b1, 4'd2, 1'b0);
    chk("pre_clr_locked", locked, 1);
    step(1'b0, 1'b1, 4'd5, 1'b1);
    chk("errclr_pulse", err_pulse, 1);
    chk("errclr_errc", err_count, 0);
    chk("errclr_sticky", err_sticky, 0);
    step(1'b0, 1'b1, 4'd0, 1'b0);
    step(1'b0, 1'b1, 4'd1, 1'b0);
    step(1'b0, 1'b1, 4'd2, 1'b0);
    step(1'b0, 1'b1, 4'd5, 1'b0);
    chk("post_errc", err_count, 1);
    chk("post_sticky", err_sticky, STICKY);
    step(1'b0, 1'b0, 4'd0, 1'b0);
    chk("hold_sticky", err_sticky, STICKY);
    chk("hold_pulse", err_pulse, 0);
    step(1'b0, 1'b0, 4'd0, 1'b1);
    chk("final_clr_errc", err_count, 0);
    chk("final_clr_sticky", err_sticky, 0);

    // 6: valid on one cycle of three, garbage on idle cycles
    for (int i = 0; i < 13; i++) begin
      step(1'b0, 1'b1, 4'(i % 10), 1'b0);
      chk("gap_vld_pulse", err_pulse, 0);
      step(1'b0, 1'b0, 4'd15, 1'b0);
      chk("gap_idle_pulse", err_pulse, 0);
      step(1'b0, 1'b0, 4'd11, 1'b0);
    end
    chk("gap_locked", locked, 1);
    chk("gap_expected", expected, 3);
    chk("gap_wrap", wrap_count, 3);
    chk("gap_errc", err_count, 0);
    // reset mid-stream drops lock on the next cycle
    step(1'b1, 1'b1, 4'd3, 1'b0);
    chk("midrst_locked", locked, 0);
    chk("midrst_expected", expected, 0);
    chk("midrst_wrap", wrap_count, 0);
    step(1'b0, 1'b0, 4'd0, 1'b0);
    chk("midrst_idle_locked", locked, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
